// File: rtl/uart_rx_mmio_pkg.sv
// uart_rx_mmio_pkg: shared constants for the memory-mapped UART receiver.
// Holds FSM state encodings, register offsets, STATUS bit indices and the STATUS layout.
package uart_rx_mmio_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 8;

    // FSM state encodings
    localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_PARITY    = 3'd4;
    localparam logic [2:0] ST_STOP      = 3'd5;

    // Register byte offsets from BASE_ADDR
    localparam logic [ADDR_W-1:0] DATA_OFS   = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] STATUS_OFS = 32'h0000_0004;

    // Write-1-to-clear STATUS bit indices
    localparam int unsigned STAT_OVR  = 1;
    localparam int unsigned STAT_FERR = 2;
    localparam int unsigned STAT_PERR = 3;

    // Oversampling tick positions within a bit
    localparam logic [3:0] MID_TICK  = 4'd7;
    localparam logic [3:0] LAST_TICK = 4'd15;

    // STATUS register layout, bit 0 = valid
    typedef struct packed {
        logic perr;
        logic ferr;
        logic overrun;
        logic valid;
    } status_t;

endpackage

// File: rtl/uart_rx_mmio_if.sv
// uart_rx_mmio_if: CPU M-bus seen by the UART receiver (address, strobes, data).
interface uart_rx_mmio_if;
    import uart_rx_mmio_pkg::*;

    logic [ADDR_W-1:0] M_addr;
    logic              M_RE;
    logic              M_WE;
    logic [31:0]       M_WData;
    logic [31:0]       M_RData;

    modport master (output M_addr, M_RE, M_WE, M_WData, input M_RData);
    modport slave  (input M_addr, M_RE, M_WE, M_WData, output M_RData);

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divide clk down to one-clock oversampling ticks; clr restarts the count.
module uart_baud_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick_c
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick_c = (cnt == CW'(DIV - 1));

    // Divisor counter, wraps after each tick
    always_ff @(posedge clk) begin
        if (reset || clr || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= CW'(cnt + 1'b1);
        end
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: 16x-oversampled UART receiver with DATA/STATUS registers on the M bus.
// Optional UART_RX_PARITY_EN macro selects 8E1 frames with a parity error flag.
module uart_rx_mmio
    import uart_rx_mmio_pkg::*;
#(
    parameter int unsigned       CLK_FREQ  = 10_000_000,
    parameter int unsigned       BAUD      = 9600,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_7F20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rxd,
    uart_rx_mmio_if.slave   bus,
    output logic            rx_irq
);
    localparam int unsigned DIV = CLK_FREQ / (16 * BAUD);

    logic              rxd_s1, rxd_s2;
    logic [2:0]        state, state_n;
    logic [3:0]        tcnt, tcnt_n;
    logic [2:0]        bitcnt, bitcnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [DATA_W-1:0] data_q, data_n;
    status_t           stat, stat_n;
    logic              tick_c, baud_clr_c;
    logic              data_rd_c, stat_wr_c;
    logic              commit_c, set_ferr_c, set_perr_c;
    logic [31:0]       rdata_c;
    logic              unused_wdata_c;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clr    (baud_clr_c),
        .tick_c (tick_c)
    );

    assign data_rd_c      = bus.M_RE && (bus.M_addr == BASE_ADDR + DATA_OFS);
    assign stat_wr_c      = bus.M_WE && (bus.M_addr == BASE_ADDR + STATUS_OFS);
    assign unused_wdata_c = ^{bus.M_WData[31:4], bus.M_WData[0]};

    // Read mux; zero for addresses outside this block
    always_comb begin
        rdata_c = '0;
        if (bus.M_addr == BASE_ADDR + DATA_OFS) begin
            rdata_c = {24'b0, data_q};
        end else if (bus.M_addr == BASE_ADDR + STATUS_OFS) begin
            rdata_c = {28'b0, stat};
        end
    end
    assign bus.M_RData = rdata_c;

    // Next-state for the frame FSM and the holding/status registers
    always_comb begin
        state_n    = state;
        tcnt_n     = tcnt;
        bitcnt_n   = bitcnt;
        shreg_n    = shreg;
        data_n     = data_q;
        stat_n     = stat;
        baud_clr_c = 1'b0;
        commit_c   = 1'b0;
        set_ferr_c = 1'b0;
        set_perr_c = 1'b0;

        case (state)
            // Line must stay high for a whole bit before arming
            ST_WAIT_IDLE: begin
                if (!rxd_s2) begin
                    tcnt_n = '0;
                end else if (tick_c) begin
                    if (tcnt == LAST_TICK) begin
                        tcnt_n  = '0;
                        state_n = ST_IDLE;
                    end else begin
                        tcnt_n = 4'(tcnt + 4'd1);
                    end
                end
            end
            ST_IDLE: begin
                if (!rxd_s2) begin
                    state_n    = ST_START;
                    tcnt_n     = '0;
                    baud_clr_c = 1'b1;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    if (tcnt == MID_TICK) begin
                        tcnt_n   = '0;
                        bitcnt_n = '0;
                        state_n  = rxd_s2 ? ST_IDLE : ST_DATA;
                    end else begin
                        tcnt_n = 4'(tcnt + 4'd1);
                    end
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    if (tcnt == LAST_TICK) begin
                        tcnt_n   = '0;
                        shreg_n  = {rxd_s2, shreg[DATA_W-1:1]};
                        bitcnt_n = 3'(bitcnt + 3'd1);
                        if (bitcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = ST_PARITY;
`else
                            state_n = ST_STOP;
`endif
                        end
                    end else begin
                        tcnt_n = 4'(tcnt + 4'd1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick_c) begin
                    if (tcnt == LAST_TICK) begin
                        tcnt_n     = '0;
                        set_perr_c = (rxd_s2 != ^shreg);
                        state_n    = ST_STOP;
                    end else begin
                        tcnt_n = 4'(tcnt + 4'd1);
                    end
                end
            end
`else
            ST_PARITY: state_n = ST_WAIT_IDLE;
`endif
            ST_STOP: begin
                if (tick_c) begin
                    if (tcnt == LAST_TICK) begin
                        tcnt_n = '0;
                        if (rxd_s2) begin
                            commit_c = 1'b1;
                            state_n  = ST_IDLE;
                        end else begin
                            set_ferr_c = 1'b1;
                            state_n    = ST_WAIT_IDLE;
                        end
                    end else begin
                        tcnt_n = 4'(tcnt + 4'd1);
                    end
                end
            end
            default: state_n = ST_WAIT_IDLE;
        endcase

        // Write-1-to-clear first so a same-cycle set wins
        if (stat_wr_c) begin
            if (bus.M_WData[STAT_OVR])  stat_n.overrun = 1'b0;
            if (bus.M_WData[STAT_FERR]) stat_n.ferr    = 1'b0;
            if (bus.M_WData[STAT_PERR]) stat_n.perr    = 1'b0;
        end

        if (commit_c) begin
            if (!stat.valid || data_rd_c) begin
                data_n       = shreg;
                stat_n.valid = 1'b1;
            end else begin
                stat_n.overrun = 1'b1;
            end
        end else if (data_rd_c) begin
            stat_n.valid = 1'b0;
        end

        if (set_ferr_c) stat_n.ferr = 1'b1;
        if (set_perr_c) stat_n.perr = 1'b1;
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            state  <= ST_WAIT_IDLE;
            tcnt   <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            data_q <= '0;
            stat   <= '0;
            rx_irq <= 1'b0;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
            state  <= state_n;
            tcnt   <= tcnt_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            data_q <= data_n;
            stat   <= stat_n;
            rx_irq <= (stat != '0);
        end
    end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio: directed bench for uart_rx_mmio at 16 clocks per bit.
// Define UART_RX_PARITY_EN for both bench and RTL to cover 8E1 frames.
module tb_uart_rx_mmio;

    localparam logic [31:0] DATA_A = 32'h0000_7F20;
    localparam logic [31:0] STAT_A = 32'h0000_7F24;

    logic clk = 1'b0;
    logic reset;
    logic rxd;
    logic rx_irq;
    int   checks = 0;
    int   errors = 0;

    uart_rx_mmio_if bus_if ();

    uart_rx_mmio #(
        .CLK_FREQ  (16000),
        .BAUD      (1000),
        .BASE_ADDR (32'h0000_7F20)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rxd    (rxd),
        .bus    (bus_if),
        .rx_irq (rx_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic b);
        rxd = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop_b, input logic par_b);
`ifndef UART_RX_PARITY_EN
        logic unused_par;
`endif
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_time(par_b);
`else
        unused_par = par_b;
`endif
        bit_time(stop_b);
        rxd = 1'b1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.M_addr = a;
        bus_if.M_RE   = 1'b1;
        #1 d = bus_if.M_RData;
        @(negedge clk);
        bus_if.M_RE   = 1'b0;
        bus_if.M_addr = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.M_addr  = a;
        bus_if.M_WData = d;
        bus_if.M_WE    = 1'b1;
        @(negedge clk);
        bus_if.M_WE    = 1'b0;
        bus_if.M_addr  = '0;
        bus_if.M_WData = '0;
    endtask

    initial begin
        logic [31:0] v;
        rxd            = 1'b1;
        reset          = 1'b1;
        bus_if.M_addr  = '0;
        bus_if.M_RE    = 1'b0;
        bus_if.M_WE    = 1'b0;
        bus_if.M_WData = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_irq", {31'b0, rx_irq}, 32'h0);
        rd(STAT_A, v); check("reset_status", v, 32'h0);
        rd(DATA_A, v); check("reset_data", v, 32'h0);
        rd(32'h0000_7F28, v); check("foreign_addr", v, 32'h0);
        reset = 1'b0;
        repeat (30) @(negedge clk);

        // 1: single byte, read clears valid
        send(8'hA5, 1'b1, 1'b0);
        rd(STAT_A, v); check("t1_status", v, 32'h1);
        check("t1_irq", {31'b0, rx_irq}, 32'h1);
        rd(DATA_A, v); check("t1_data", v, 32'h0000_00A5);
        rd(STAT_A, v); check("t1_status_after", v, 32'h0);
        check("t1_irq_after", {31'b0, rx_irq}, 32'h0);

        // 2: overrun keeps the first byte; W1C overrun
        send(8'h3C, 1'b1, 1'b0);
        send(8'h7E, 1'b1, 1'b0);
        rd(STAT_A, v); check("t2_status_ovr", v, 32'h3);
        wr(STAT_A, 32'h2);
        rd(STAT_A, v); check("t2_status_w1c", v, 32'h1);
        rd(DATA_A, v); check("t2_data", v, 32'h0000_003C);
        rd(STAT_A, v); check("t2_status_after", v, 32'h0);

        // 3: framing error drops byte; DATA read without valid has no effect
        send(8'h55, 1'b0, 1'b0);
        rd(STAT_A, v); check("t3_status_ferr", v, 32'h4);
        rd(DATA_A, v); check("t3_data_stale", v, 32'h0000_003C);
        rd(STAT_A, v); check("t3_status_kept", v, 32'h4);
        check("t3_irq", {31'b0, rx_irq}, 32'h1);
        repeat (20) @(negedge clk);
        send(8'h12, 1'b1, 1'b0);
        rd(STAT_A, v); check("t3_status_next", v, 32'h5);
        wr(STAT_A, 32'hF);
        rd(STAT_A, v); check("t3_status_w1c", v, 32'h1);
        rd(DATA_A, v); check("t3_data_next", v, 32'h0000_0012);
        rd(STAT_A, v); check("t3_status_clear", v, 32'h0);

        // 4: short low glitch is rejected
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        rd(STAT_A, v); check("t4_status_glitch", v, 32'h0);
        check("t4_irq", {31'b0, rx_irq}, 32'h0);
        send(8'h5A, 1'b1, 1'b0);
        rd(STAT_A, v); check("t4_status_after", v, 32'h1);

        // 5: reset during data bit 3 with the line held low
        bit_time(1'b0);
        bit_time(1'b0);
        bit_time(1'b0);
        bit_time(1'b0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("t5_irq_reset", {31'b0, rx_irq}, 32'h0);
        rd(STAT_A, v); check("t5_status_reset", v, 32'h0);
        rd(DATA_A, v); check("t5_data_reset", v, 32'h0);
        repeat (60) @(negedge clk);
        rd(STAT_A, v); check("t5_status_low", v, 32'h0);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        rd(STAT_A, v); check("t5_status_idle", v, 32'h0);
        send(8'h81, 1'b1, 1'b0);
        rd(STAT_A, v); check("t5_status_rx", v, 32'h1);
        rd(DATA_A, v); check("t5_data_rx", v, 32'h0000_0081);

`ifdef UART_RX_PARITY_EN
        // 6: parity error still commits the byte
        send(8'h07, 1'b1, 1'b0);
        rd(STAT_A, v); check("t6_status_perr", v, 32'h9);
        rd(DATA_A, v); check("t6_data_perr", v, 32'h0000_0007);
        wr(STAT_A, 32'h8);
        rd(STAT_A, v); check("t6_status_w1c", v, 32'h0);
        send(8'h07, 1'b1, 1'b1);
        rd(STAT_A, v); check("t6_status_ok", v, 32'h1);
        rd(DATA_A, v); check("t6_data_ok", v, 32'h0000_0007);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
